tdm_demux8: RTL and testbench



---
 rtl/tdm_demux8.sv | 121 ++++++++++++
 tb/tb_tdm_demux8.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux8.sv
// 8-slot TDM receive demultiplexer: gathers slots 0..7 into a shadow register and
// presents a full frame in parallel. Optional err_cnt output via TDM_DEMUX_ERR_CNT_EN.
module tdm_demux8 #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   din,
  input  logic               din_valid,
  input  logic               frame_sync,
  output logic [8*WIDTH-1:0] dout,
  output logic               dout_valid,
  output logic [2:0]         slot,
  output logic               locked,
  output logic               sync_err
`ifdef TDM_DEMUX_ERR_CNT_EN
  ,
  output logic [7:0]         err_cnt
`endif
);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t             state_reg;
  logic [2:0]         slot_reg;
  logic [8*WIDTH-1:0] dout_reg;
  logic               dout_valid_reg;
  logic               sync_err_reg;
  logic [WIDTH-1:0]   shadow_reg [0:6];
  logic [8*WIDTH-1:0] frame_next;
  logic               err_event;
  logic               store_event;

  // Early sync (mid-frame) and missing sync (at slot 0) both count as misalignment.
  assign err_event   = din_valid && (state_reg == LOCKED) &&
                       (frame_sync ? (slot_reg != 3'd0) : (slot_reg == 3'd0));
  assign store_event = din_valid && !frame_sync && (state_reg == LOCKED) && (slot_reg != 3'd0);

  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_shadow
      logic wr_en;
      if (gi == 0) begin : g_first
        assign wr_en = din_valid && frame_sync;
      end else begin : g_rest
        assign wr_en = store_event && (slot_reg == 3'(gi));
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          shadow_reg[gi] <= '0;
        end else if (wr_en) begin
          shadow_reg[gi] <= din;
        end
      end

      assign frame_next[gi*WIDTH +: WIDTH] = shadow_reg[gi];
    end
  endgenerate

  // Slot 7 bypasses the shadow so the frame lands on dout one cycle after it arrives.
  assign frame_next[7*WIDTH +: WIDTH] = din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= HUNT;
      slot_reg       <= 3'd0;
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
      sync_err_reg   <= 1'b0;
    end else begin
      dout_valid_reg <= 1'b0;
      sync_err_reg   <= err_event;
      if (din_valid) begin
        case (state_reg)
          HUNT: begin
            if (frame_sync) begin
              slot_reg  <= 3'd1;
              state_reg <= LOCKED;
            end
          end
          LOCKED: begin
            if (frame_sync) begin
              slot_reg <= 3'd1;
            end else if (slot_reg == 3'd0) begin
              state_reg <= HUNT;
            end else if (slot_reg == 3'd7) begin
              dout_reg       <= frame_next;
              dout_valid_reg <= 1'b1;
              slot_reg       <= 3'd0;
            end else begin
              slot_reg <= slot_reg + 3'd1;
            end
          end
          default: state_reg <= HUNT;
        endcase
      end
    end
  end

  assign dout       = dout_reg;
  assign dout_valid = dout_valid_reg;
  assign slot       = slot_reg;
  assign locked     = (state_reg == LOCKED);
  assign sync_err   = sync_err_reg;

`ifdef TDM_DEMUX_ERR_CNT_EN
  logic [7:0] err_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_reg <= 8'd0;
    end else if (err_event && (err_cnt_reg != 8'hFF)) begin
      err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end

  assign err_cnt = err_cnt_reg;
`endif

endmodule

// File: tb/tb_tdm_demux8.sv
// Scoreboard bench for tdm_demux8: driver pushes per-cycle expectations from a
// queue-based frame model, monitor pops and compares after each clock edge.
module tb_tdm_demux8;
  localparam int W = 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [W-1:0]   din = '0;
  logic           din_valid = 1'b0;
  logic           frame_sync = 1'b0;
  logic [8*W-1:0] dout;
  logic           dout_valid;
  logic [2:0]     slot;
  logic           locked;
  logic           sync_err;
`ifdef TDM_DEMUX_ERR_CNT_EN
  logic [7:0]     err_cnt;
`endif

  tdm_demux8 #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .dout       (dout),
    .dout_valid (dout_valid),
    .slot       (slot),
    .locked     (locked),
    .sync_err   (sync_err)
`ifdef TDM_DEMUX_ERR_CNT_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic           dv;
    logic           err;
    logic           lk;
    logic [2:0]     sl;
    logic [8*W-1:0] dout;
    logic [7:0]     ecnt;
  } exp_t;

  exp_t         exp_q[$];
  int           checks = 0;
  int           errors = 0;

  // Reference model: a frame is just the list of samples gathered since the last sync.
  logic [W-1:0]   frame[$];
  bit             m_locked = 0;
  logic [8*W-1:0] m_dout = '0;
  int             m_errs = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input bit v, input logic [W-1:0] d, input bit fs);
    exp_t e;
    @(negedge clk);
    din_valid = v; din = d; frame_sync = fs;
    e = '0;
    if (v) begin
      if (fs) begin
        if (m_locked && frame.size() != 0) e.err = 1'b1;
        frame.delete();
        frame.push_back(d);
        m_locked = 1;
      end else if (m_locked) begin
        if (frame.size() == 0) begin
          e.err = 1'b1;
          m_locked = 0;
        end else begin
          frame.push_back(d);
          if (frame.size() == 8) begin
            for (int k = 0; k < 8; k++) m_dout[k*W +: W] = frame[k];
            e.dv = 1'b1;
            frame.delete();
          end
        end
      end
    end
    if (e.err) m_errs++;
    e.lk   = m_locked;
    e.sl   = 3'(frame.size());
    e.dout = m_dout;
    e.ecnt = (m_errs > 255) ? 8'd255 : 8'(m_errs);
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; din_valid = 1'b0; frame_sync = 1'b0;
    #1;
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_dout_valid", 64'(dout_valid), 64'd0);
    chk("rst_slot", 64'(slot), 64'd0);
    chk("rst_locked", 64'(locked), 64'd0);
    chk("rst_sync_err", 64'(sync_err), 64'd0);
`ifdef TDM_DEMUX_ERR_CNT_EN
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
`endif
    frame.delete(); m_locked = 0; m_dout = '0; m_errs = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Sync'd frame from an 8-bit pattern, slot k taking bit k.
  task automatic send_frame(input logic [7:0] pat);
    for (int k = 0; k < 8; k++) drive(1'b1, W'(pat[k]), k == 0);
  endtask

  task automatic expect_frame(input string nm, input logic [7:0] val);
    @(posedge clk); #3;
    chk({nm, "_dout"}, 64'(dout), 64'(val));
    chk({nm, "_valid"}, 64'(dout_valid), 64'd1);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #2;
      if (rst_n) begin
        chk("excl_dv_err", 64'(dout_valid & sync_err), 64'd0);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("dout_valid", 64'(dout_valid), 64'(e.dv));
          chk("sync_err", 64'(sync_err), 64'(e.err));
          chk("locked", 64'(locked), 64'(e.lk));
          chk("slot", 64'(slot), 64'(e.sl));
          chk("dout", 64'(dout), 64'(e.dout));
`ifdef TDM_DEMUX_ERR_CNT_EN
          chk("err_cnt", 64'(err_cnt), 64'(e.ecnt));
`endif
        end else begin
          chk("unexpected_pulse", 64'(dout_valid | sync_err), 64'd0);
        end
      end
    end
  end

  // Driver
  initial begin
    logic [7:0] pat;
    do_reset();

    send_frame(8'h01); expect_frame("plan_frame1", 8'h01);
    send_frame(8'h80); expect_frame("plan_b2b_a", 8'h80);
    send_frame(8'h0F); expect_frame("plan_b2b_b", 8'h0F);

    // Early sync on the 4th sample, then a full all-ones frame from it
    for (int k = 0; k < 3; k++) drive(1'b1, '0, k == 0);
    send_frame(8'hFF); expect_frame("plan_early_sync", 8'hFF);

    // Missing sync: unlock, drop samples until the next sync
    for (int k = 0; k < 4; k++) drive(1'b1, '1, 1'b0);
    send_frame(8'h5A);

    // Idle gaps between samples
    pat = 8'hC3;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, W'(pat[k]), k == 0);
      if (k < 3) drive(1'b0, W'(~pat[k]), 1'b1);
    end
    expect_frame("plan_gaps", 8'hC3);

    // Reset mid-frame, then no sync: nothing must come out
    for (int k = 0; k < 5; k++) drive(1'b1, '1, k == 0);
    do_reset();
    for (int k = 0; k < 8; k++) drive(1'b1, '1, 1'b0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      bit v, fs;
      v  = ($urandom_range(0, 9) < 8);
      fs = (frame.size() == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 24) == 0);
      drive(v, W'($urandom), fs);
    end

`ifdef TDM_DEMUX_ERR_CNT_EN
    do_reset();
    for (int n = 0; n < 301; n++) drive(1'b1, W'($urandom), 1'b1);
    @(posedge clk); #3;
    chk("err_cnt_saturate", 64'(err_cnt), 64'd255);
`endif

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #4;
    chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
